upbus_master: RTL

- Microprocessor-side initiator for the upen/upws/uprs/upa/updi/updo/uprdy register/RAM access bus used by the engine RAM buffers.
- Converts a level req/ack host request into a correctly framed bus access: upen held for the whole access, a one-cycle read or write strobe, then a wait for uprdy.
- Captures updo on uprdy and returns it to the host.
- Terminates hung accesses with a timeout error and a fixed read-back value.

---
 rtl/upbus_master_if.sv | 16 +
 rtl/upbus_master.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/upbus_master_if.sv
// rtl/upbus_master_if.sv - upen/upws/uprs/upa/updi/updo/uprdy access bus between initiator and RAM slave
interface upbus_master_if #(
  parameter int ADDRBIT = 5,
  parameter int WIDTH   = 32
);
  logic               upen;
  logic               upws;
  logic               uprs;
  logic [ADDRBIT-1:0] upa;
  logic [WIDTH-1:0]   updi;
  logic [WIDTH-1:0]   updo;
  logic               uprdy;

  modport master (output upen, upws, uprs, upa, updi, input updo, uprdy);
  modport slave  (input upen, upws, uprs, upa, updi, output updo, uprdy);
endinterface

// File: rtl/upbus_master.sv
// rtl/upbus_master.sv - req/ack host to upbus initiator with timeout; UPMST_RETRY_EN adds one retry per access
module upbus_master #(
  parameter int               ADDRBIT = 5,
  parameter int               WIDTH   = 32,
  parameter int               CNTBIT  = 8,
  parameter int               TOUT    = 255,
  parameter logic [WIDTH-1:0] TOVAL   = 32'hDEADBEEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cpu_req,
  input  logic               cpu_wr,
  input  logic [ADDRBIT-1:0] cpu_addr,
  input  logic [WIDTH-1:0]   cpu_wdata,
  output logic               cpu_ack,
  output logic               cpu_err,
  output logic [WIDTH-1:0]   cpu_rdata,
  output logic               cpu_busy,
  output logic [7:0]         err_cnt,
  input  logic               err_clr,
  upbus_master_if.master     bus
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_STROBE = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_DONE   = 3'd3;
  localparam logic [2:0] S_RETRY  = 3'd4;

  localparam logic [CNTBIT-1:0] TOUT_C = CNTBIT'(TOUT);

  logic [2:0]         state;
  logic               wr_q;
  logic [CNTBIT-1:0]  cnt;
  logic               upen_q;
  logic               upws_q;
  logic               uprs_q;
  logic [ADDRBIT-1:0] upa_q;
  logic [WIDTH-1:0]   updi_q;
  logic               hit;
  logic               tmo;
  logic               retry_go;
  logic               fin_err;
`ifdef UPMST_RETRY_EN
  logic               retried;
`endif

  assign bus.upen = upen_q;
  assign bus.upws = upws_q;
  assign bus.uprs = uprs_q;
  assign bus.upa  = upa_q;
  assign bus.updi = updi_q;

  // cnt holds the number of cycles since the strobe while in WAIT; uprdy beats timeout
  always_comb begin
    hit = ((state == S_STROBE) || (state == S_WAIT)) && bus.uprdy;
    tmo = (state == S_WAIT) && !bus.uprdy && (cnt == TOUT_C);
`ifdef UPMST_RETRY_EN
    retry_go = tmo && !retried;
`else
    retry_go = 1'b0;
`endif
    fin_err = tmo && !retry_go;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      wr_q      <= 1'b0;
      cnt       <= '0;
      upen_q    <= 1'b0;
      upws_q    <= 1'b0;
      uprs_q    <= 1'b0;
      upa_q     <= '0;
      updi_q    <= '0;
      cpu_ack   <= 1'b0;
      cpu_err   <= 1'b0;
      cpu_rdata <= '0;
      cpu_busy  <= 1'b0;
      err_cnt   <= '0;
`ifdef UPMST_RETRY_EN
      retried   <= 1'b0;
`endif
    end else begin
      upws_q  <= 1'b0;
      uprs_q  <= 1'b0;
      cpu_ack <= 1'b0;
      cpu_err <= 1'b0;

      if (err_clr)
        err_cnt <= '0;
      else if (fin_err && (err_cnt != 8'hFF))
        err_cnt <= err_cnt + 8'd1;

`ifdef UPMST_RETRY_EN
      if (state == S_IDLE)
        retried <= 1'b0;
      else if (retry_go)
        retried <= 1'b1;
`endif

      case (state)
        S_IDLE: begin
          if (cpu_req) begin
            state    <= S_STROBE;
            upa_q    <= cpu_addr;
            updi_q   <= cpu_wdata;
            wr_q     <= cpu_wr;
            upen_q   <= 1'b1;
            upws_q   <= cpu_wr;
            uprs_q   <= !cpu_wr;
            cpu_busy <= 1'b1;
          end
        end
        S_STROBE, S_WAIT: begin
          cnt <= (state == S_STROBE) ? CNTBIT'(1) : cnt + CNTBIT'(1);
          if (hit) begin
            state   <= S_DONE;
            upen_q  <= 1'b0;
            cpu_ack <= 1'b1;
            if (!wr_q)
              cpu_rdata <= bus.updo;
          end else if (retry_go) begin
            state  <= S_RETRY;
            upen_q <= 1'b0;
          end else if (fin_err) begin
            state     <= S_DONE;
            upen_q    <= 1'b0;
            cpu_ack   <= 1'b1;
            cpu_err   <= 1'b1;
            cpu_rdata <= TOVAL;
          end else begin
            state <= S_WAIT;
          end
        end
        S_RETRY: begin
          state  <= S_STROBE;
          upen_q <= 1'b1;
          upws_q <= wr_q;
          uprs_q <= !wr_q;
        end
        S_DONE: begin
          state    <= S_IDLE;
          cpu_busy <= 1'b0;
        end
        default: begin
          state    <= S_IDLE;
          upen_q   <= 1'b0;
          cpu_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
